regfile_port_sequencer: RTL and testbench
=========================================

Name: regfile_port_sequencer

Overview:
- Controller in front of the single-port register file (one shared select, load strobe, write data in, read data out).
- Gives the core's decode/ALU stage two independent ready/valid channels:
  - a two-operand read (srcA, srcB), which it serialises into two select phases;
  - a single-register writeback.
- Owns every register-file port drive. Nothing else in the core touches the register file directly.

Parameters:
- SELECT_WIDTH, 4, width of the register select; the register file holds 2**SELECT_WIDTH entries.
- REG_WIDTH, 8, data width of each register.

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_rdValid  in  1  operand-read request.
- o_rdReady  out  1  read request accepted this cycle when i_rdValid && o_rdReady.
- i_rdSelA  in  SELECT_WIDTH  first operand register.
- i_rdSelB  in  SELECT_WIDTH  second operand register.
- o_opValid  out  1  one-cycle pulse; o_opA and o_opB are valid.
- o_opA  out  REG_WIDTH  captured contents of srcA; held until the next capture.
- o_opB  out  REG_WIDTH  captured contents of srcB; held until the next capture.
- i_wrValid  in  1  writeback request.
- o_wrReady  out  1  write request accepted this cycle when i_wrValid && o_wrReady.
- i_wrSel  in  SELECT_WIDTH  destination register.
- i_wrData  in  REG_WIDTH  value to write.
- o_rfLdSig  out  1  drives the register file load signal.
- o_rfSel  out  SELECT_WIDTH  drives the register file select.
- o_rfData  out  REG_WIDTH  drives the register file write data.
- i_rfData  in  REG_WIDTH  register file read data.
- o_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- FSM states: IDLE, WRITE, RDA_SET, RDA_CAP, RDB_SET, RDB_CAP, DONE.
- Reset values (i_rst high at a clock edge):
  - state = IDLE;
  - o_opA = 0, o_opB = 0;
  - o_opValid = 0, o_rfLdSig = 0;
  - o_rfSel = 0, o_rfData = 0.
  - Reset mid-operation aborts the operation: no o_opValid pulse and no o_rfLdSig assertion afterwards.
- Ready signals are combinational from state and inputs:
  - o_wrReady = (state == IDLE);
  - o_rdReady = (state == IDLE) && !i_wrValid.
- Arbitration: when both channels are valid in IDLE, the write wins and the read waits. A read of the register being written therefore always sees the new value.
- Both requests are latched at acceptance; inputs may change afterwards.
- Write sequence (write accepted at cycle 0):
  - cycle 1: state WRITE, o_rfLdSig = 1, o_rfSel = wrSel, o_rfData = wrData;
  - cycle 2: IDLE, o_rfLdSig = 0.
  - Exactly one load cycle per accepted write.
- Read sequence (read accepted at cycle 0):
  - cycle 1: RDA_SET, o_rfSel = selA.
  - cycle 2: RDA_CAP, o_rfSel still selA; o_opA <= i_rfData at the end of this cycle.
  - cycle 3: RDB_SET, o_rfSel = selB.
  - cycle 4: RDB_CAP; o_opB <= i_rfData at the end of this cycle.
  - cycle 5: DONE, o_opValid = 1.
  - cycle 6: IDLE.
  - The two-cycle hold per phase tolerates both combinational and registered read data from the register file.
- Fast path when selA == selB:
  - after RDA_CAP go directly to DONE;
  - o_opB is loaded with the same value as o_opA at the RDA_CAP edge;
  - o_opValid appears at cycle 3.
- o_rfLdSig is 0 in every state except WRITE.
- o_rfSel and o_rfData hold their last value while in IDLE.
- o_opValid is high only in DONE. There is no back-pressure on operands; the consumer must sample on the pulse.
- Back-to-back: a request presented in the same cycle the FSM returns to IDLE is accepted that cycle.

Decomposition:
- Shared package (regfile_pkg):
  - SELECT_WIDTH and REG_WIDTH defaults;
  - the FSM state enum (3-bit encoding).
  - The register file and this sequencer both import it.
- No sub-module needed. The FSM and the operand capture registers live in one module.
- The bench instantiates this sequencer wired to the existing register file.

Test Plan:
1. Write 10 to r0, then 20 to r3, each as a single request -> one o_rfLdSig pulse per write, o_rfSel = 0 then 3, o_wrReady high at cycles 0 and 2.
2. Read (A=0, B=3) after test 1 -> o_opValid exactly 5 cycles after acceptance, o_opA = 10, o_opB = 20, o_rdReady low during cycles 1-5.
3. Read (A=3, B=3) -> o_opValid 3 cycles after acceptance, o_opA = o_opB = 20, o_rfSel never changes from 3.
4. Simultaneous write 55 to r3 and read (A=3, B=0) in IDLE -> write accepted first, read accepted 2 cycles later, o_opA = 55, o_opB = 10.
5. Assert i_rst during RDB_SET of a read -> next cycle state IDLE, o_opA = 0, o_opB = 0, no o_opValid pulse; a subsequent read of r0 returns 10.
6. Change i_rdSelA/i_rdSelB/i_wrData to garbage the cycle after acceptance -> captured operands and written value still match the originally accepted requests.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the single-port register file and its port
//   sequencer: default geometry and the sequencer FSM state encoding.
package regfile_pkg;

    localparam int DEF_SELECT_WIDTH = 4;  // register file holds 2**SELECT_WIDTH entries
    localparam int DEF_REG_WIDTH    = 8;  // data width of each register

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RDA_SET = 3'd2,
        RDA_CAP = 3'd3,
        RDB_SET = 3'd4,
        RDB_CAP = 3'd5,
        DONE    = 3'd6
    } rfSeqState_e;

endpackage

// File: rtl/regfile_port_sequencer.sv
// regfile_port_sequencer
//   Sole driver of the single-port register file. Offers the decode/ALU
//   stage a two-operand read channel (serialised into two select phases)
//   and a single-register writeback channel.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_rdValid/o_rdReady     operand-read request handshake, i_rdSelA/i_rdSelB
//   o_opValid, o_opA, o_opB one-cycle operand pulse, operands held until next capture
//   i_wrValid/o_wrReady     writeback handshake, i_wrSel/i_wrData
//   o_rfLdSig/o_rfSel/o_rfData/i_rfData  register file port
//   o_busy                  FSM is not in IDLE
//   o_state                 current FSM state, for observation only
//
// Handshake: a request transfers on a rising edge where valid && ready are
// both high. Ready depends only on the current state (and, for reads, on a
// competing write); request fields are latched at that edge, so the
// requester may change them freely afterwards.
module regfile_port_sequencer
    import regfile_pkg::*;
#(
    parameter int SELECT_WIDTH = DEF_SELECT_WIDTH,
    parameter int REG_WIDTH    = DEF_REG_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_rdValid,
    output logic                    o_rdReady,
    input  logic [SELECT_WIDTH-1:0] i_rdSelA,
    input  logic [SELECT_WIDTH-1:0] i_rdSelB,
    output logic                    o_opValid,
    output logic [REG_WIDTH-1:0]    o_opA,
    output logic [REG_WIDTH-1:0]    o_opB,
    input  logic                    i_wrValid,
    output logic                    o_wrReady,
    input  logic [SELECT_WIDTH-1:0] i_wrSel,
    input  logic [REG_WIDTH-1:0]    i_wrData,
    output logic                    o_rfLdSig,
    output logic [SELECT_WIDTH-1:0] o_rfSel,
    output logic [REG_WIDTH-1:0]    o_rfData,
    input  logic [REG_WIDTH-1:0]    i_rfData,
    output logic                    o_busy,
    output rfSeqState_e             o_state
);

    rfSeqState_e             state;
    logic [SELECT_WIDTH-1:0] selB;     // second operand select, latched at acceptance
    logic                    sameSel;  // both operands name the same register
    logic                    wrAccept;
    logic                    rdAccept;

    // A pending write blocks the read, so a read of the register being
    // written always observes the new value.
    assign o_wrReady = (state == IDLE);
    assign o_rdReady = (state == IDLE) && !i_wrValid;
    assign wrAccept  = i_wrValid && o_wrReady;
    assign rdAccept  = i_rdValid && o_rdReady;
    assign o_busy    = (state != IDLE);
    assign o_state   = state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            selB      <= '0;
            sameSel   <= 1'b0;
            o_opA     <= '0;
            o_opB     <= '0;
            o_opValid <= 1'b0;
            o_rfLdSig <= 1'b0;
            o_rfSel   <= '0;
            o_rfData  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // o_rfSel/o_rfData deliberately keep their last value here.
                    if (wrAccept) begin
                        o_rfLdSig <= 1'b1;
                        o_rfSel   <= i_wrSel;
                        o_rfData  <= i_wrData;
                        state     <= WRITE;
                    end else if (rdAccept) begin
                        o_rfSel <= i_rdSelA;
                        selB    <= i_rdSelB;
                        sameSel <= (i_rdSelA == i_rdSelB);
                        state   <= RDA_SET;
                    end
                end
                WRITE: begin
                    o_rfLdSig <= 1'b0;
                    state     <= IDLE;
                end
                // Each select is held for two cycles so registered read data
                // has settled by the capture edge.
                RDA_SET: state <= RDA_CAP;
                RDA_CAP: begin
                    o_opA <= i_rfData;
                    if (sameSel) begin
                        o_opB     <= i_rfData;
                        o_opValid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        o_rfSel <= selB;
                        state   <= RDB_SET;
                    end
                end
                RDB_SET: state <= RDB_CAP;
                RDB_CAP: begin
                    o_opB     <= i_rfData;
                    o_opValid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    o_opValid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    o_opValid <= 1'b0;
                    o_rfLdSig <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// tb_regfile_port_sequencer
//   Directed bench for regfile_port_sequencer wired to a behavioural
//   single-port register file (combinational read, write on load strobe).
module tb_regfile_port_sequencer;
    import regfile_pkg::*;

    localparam int SW = DEF_SELECT_WIDTH;
    localparam int RW = DEF_REG_WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdValid;
    logic          rdReady;
    logic [SW-1:0] rdSelA;
    logic [SW-1:0] rdSelB;
    logic          opValid;
    logic [RW-1:0] opA;
    logic [RW-1:0] opB;
    logic          wrValid;
    logic          wrReady;
    logic [SW-1:0] wrSel;
    logic [RW-1:0] wrData;
    logic          rfLdSig;
    logic [SW-1:0] rfSel;
    logic [RW-1:0] rfDataOut;
    logic [RW-1:0] rfDataIn;
    logic          busy;
    rfSeqState_e   state;

    int checks   = 0;
    int failures = 0;
    int ldCount  = 0;
    int vldCount = 0;
    logic [2*RW-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- register file model ----------------
    logic [RW-1:0] rfMem[2**SW];
    assign rfDataIn = rfMem[rfSel];
    always @(posedge clk) if (rfLdSig) rfMem[rfSel] <= rfDataOut;

    regfile_port_sequencer dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_rdValid(rdValid),
        .o_rdReady(rdReady),
        .i_rdSelA (rdSelA),
        .i_rdSelB (rdSelB),
        .o_opValid(opValid),
        .o_opA    (opA),
        .o_opB    (opB),
        .i_wrValid(wrValid),
        .o_wrReady(wrReady),
        .i_wrSel  (wrSel),
        .i_wrData (wrData),
        .o_rfLdSig(rfLdSig),
        .o_rfSel  (rfSel),
        .o_rfData (rfDataOut),
        .i_rfData (rfDataIn),
        .o_busy   (busy),
        .o_state  (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rfLdSig) ldCount++;
        if (opValid) begin
            vldCount++;
            if (exp_q.size() == 0) begin
                check("unexpected_opValid", 32'(vldCount), 32'(0));
            end else begin
                logic [2*RW-1:0] e;
                e = exp_q.pop_front();
                check("sb_opA", 32'(opA), 32'(e[2*RW-1:RW]));
                check("sb_opB", 32'(opB), 32'(e[RW-1:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a write in the current cycle; returns in cycle 2 (IDLE).
    task automatic doWrite(input logic [SW-1:0] s, input logic [RW-1:0] d);
        int ld0;
        ld0     = ldCount;
        wrValid = 1'b1;
        wrSel   = s;
        wrData  = d;
        #1;
        check("wr_ready_c0", 32'(wrReady), 32'(1));
        tick();
        wrValid = 1'b0;
        wrSel   = ~s;
        wrData  = ~d;
        check("wr_state_c1", 32'(state), 32'(WRITE));
        check("wr_ld_c1", 32'(rfLdSig), 32'(1));
        check("wr_sel_c1", 32'(rfSel), 32'(s));
        check("wr_data_c1", 32'(rfDataOut), 32'(d));
        check("wr_ready_c1", 32'(wrReady), 32'(0));
        tick();
        check("wr_ld_c2", 32'(rfLdSig), 32'(0));
        check("wr_ready_c2", 32'(wrReady), 32'(1));
        check("wr_sel_hold_c2", 32'(rfSel), 32'(s));
        check("wr_ld_pulses", 32'(ldCount - ld0), 32'(1));
    endtask

    // Read request already driven and about to be accepted at the next edge.
    task automatic readBody(input logic [SW-1:0] a, input logic [SW-1:0] b,
                            input logic [RW-1:0] ea, input logic [RW-1:0] eb);
        int lat;
        lat = (a == b) ? 3 : 5;
        #1;
        check("rd_ready_c0", 32'(rdReady), 32'(1));
        exp_q.push_back({ea, eb});
        tick();
        rdValid = 1'b0;
        rdSelA  = ~a;
        rdSelB  = ~b;
        for (int k = 1; k < lat; k++) begin
            check("rd_opValid_low", 32'(opValid), 32'(0));
            check("rd_ready_low", 32'(rdReady), 32'(0));
            if (k <= 2) check("rd_sel_a", 32'(rfSel), 32'(a));
            else        check("rd_sel_b", 32'(rfSel), 32'(b));
            tick();
        end
        check("rd_opValid_pulse", 32'(opValid), 32'(1));
        check("rd_state_done", 32'(state), 32'(DONE));
        check("rd_opA", 32'(opA), 32'(ea));
        check("rd_opB", 32'(opB), 32'(eb));
        check("rd_ready_done", 32'(rdReady), 32'(0));
        tick();
        check("rd_opValid_end", 32'(opValid), 32'(0));
        check("rd_state_idle", 32'(state), 32'(IDLE));
        check("rd_ready_idle", 32'(rdReady), 32'(1));
        check("rd_opA_hold", 32'(opA), 32'(ea));
    endtask

    task automatic doRead(input logic [SW-1:0] a, input logic [SW-1:0] b,
                          input logic [RW-1:0] ea, input logic [RW-1:0] eb);
        rdValid = 1'b1;
        rdSelA  = a;
        rdSelB  = b;
        readBody(a, b, ea, eb);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int v0;
        int l0;
        rst     = 1'b1;
        rdValid = 1'b0;
        rdSelA  = '0;
        rdSelB  = '0;
        wrValid = 1'b0;
        wrSel   = '0;
        wrData  = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'(IDLE));
        check("rst_opA", 32'(opA), 32'(0));
        check("rst_opB", 32'(opB), 32'(0));
        check("rst_opValid", 32'(opValid), 32'(0));
        check("rst_ld", 32'(rfLdSig), 32'(0));
        check("rst_rfSel", 32'(rfSel), 32'(0));
        check("rst_rfData", 32'(rfDataOut), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_wrReady", 32'(wrReady), 32'(1));
        check("rst_rdReady", 32'(rdReady), 32'(1));

        // 1: two back-to-back writes
        doWrite(4'd0, 8'd10);
        doWrite(4'd3, 8'd20);

        // 2: two-phase read
        doRead(4'd0, 4'd3, 8'd10, 8'd20);

        // 3: same-register fast path
        doRead(4'd3, 4'd3, 8'd20, 8'd20);

        // 4: simultaneous write and read; write wins
        wrValid = 1'b1;
        wrSel   = 4'd3;
        wrData  = 8'd55;
        rdValid = 1'b1;
        rdSelA  = 4'd3;
        rdSelB  = 4'd0;
        #1;
        check("arb_wrReady", 32'(wrReady), 32'(1));
        check("arb_rdReady", 32'(rdReady), 32'(0));
        tick();
        wrValid = 1'b0;
        wrData  = 8'hEE;
        check("arb_state_write", 32'(state), 32'(WRITE));
        check("arb_rdReady_c1", 32'(rdReady), 32'(0));
        tick();
        check("arb_state_idle_c2", 32'(state), 32'(IDLE));
        readBody(4'd3, 4'd0, 8'd55, 8'd10);

        // 5: reset during RDB_SET aborts the read
        v0      = vldCount;
        l0      = ldCount;
        rdValid = 1'b1;
        rdSelA  = 4'd0;
        rdSelB  = 4'd3;
        tick();
        rdValid = 1'b0;
        tick();
        tick();
        check("abort_state_rdb_set", 32'(state), 32'(RDB_SET));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_state", 32'(state), 32'(IDLE));
        check("abort_opA", 32'(opA), 32'(0));
        check("abort_opB", 32'(opB), 32'(0));
        for (int k = 0; k < 6; k++) tick();
        check("abort_no_opValid", 32'(vldCount - v0), 32'(0));
        check("abort_no_ld", 32'(ldCount - l0), 32'(0));
        doRead(4'd0, 4'd0, 8'd10, 8'd10);

        // 6: garbage after acceptance is covered inside the driver tasks;
        // one more write/read pair with distinct data confirms it.
        doWrite(4'd9, 8'hA5);
        doRead(4'd9, 4'd3, 8'hA5, 8'd55);

        tick();
        check("sb_queue_empty", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
